// File: rtl/matmul_pkg.sv
// Shared types and sizes for the matrix-multiply operand path.
package matmul_pkg;

    localparam int unsigned DIM    = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned IDX_W  = 6;
    localparam int unsigned K_W    = $clog2(DIM);

    typedef logic [DIM-1:0][BYTE_W-1:0] vec_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        DONE,
        ERR
    } fetch_state_t;

endpackage

// File: rtl/rd_tag_pipe.sv
// Shift register that tracks in-flight BRAM reads: a valid bit and element index
// travel alongside the read so the returning data can be written to the right slot.
module rd_tag_pipe #(
    parameter int unsigned Depth = 2,
    parameter int unsigned IdxW  = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic [IdxW-1:0] push_idx_i,
    output logic            cap_valid_o,
    output logic [IdxW-1:0] cap_idx_o
);

    logic [Depth-1:0]           valid_q;
    logic [Depth-1:0][IdxW-1:0] idx_q;

    // Advance every tag one stage per cycle; stage Depth-1 lines up with the BRAM data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            idx_q   <= '0;
        end else begin
            valid_q[0] <= push_i;
            idx_q[0]   <= push_idx_i;
            for (int i = 1; i < Depth; i++) begin
                valid_q[i] <= valid_q[i-1];
                idx_q[i]   <= idx_q[i-1];
            end
        end
    end

    assign cap_valid_o = valid_q[Depth-1];
    assign cap_idx_o   = idx_q[Depth-1];

endmodule

// File: rtl/operand_fetch.sv
// Fetches row `row` of A and column `col` of B from two byte-wide BRAMs and
// delivers them as DIM-byte vectors with a one-cycle val_rows pulse.
module operand_fetch
    import matmul_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned ADDR_W       = 10
) (
    input  logic                           clk_in,
    input  logic                           rst_in,
    input  logic                           new_request,
    input  logic [IDX_W-1:0]               row_req,
    input  logic [IDX_W-1:0]               col_req,
    output logic [ADDR_W-1:0]              a_addr,
    input  logic [BYTE_W-1:0]              a_data,
    output logic [ADDR_W-1:0]              b_addr,
    input  logic [BYTE_W-1:0]              b_data,
    output logic                           mem_en,
    output logic [DIM-1:0][BYTE_W-1:0]     matA_row,
    output logic [DIM-1:0][BYTE_W-1:0]     matB_col,
    output logic [IDX_W-1:0]               row_in,
    output logic [IDX_W-1:0]               col_in,
    output logic                           val_rows,
    output logic                           busy,
    output logic                           range_err
);

    localparam logic [K_W-1:0]   KLast  = K_W'(DIM - 1);
    localparam logic [IDX_W-1:0] IdxLim = IDX_W'(DIM);

    fetch_state_t     state_q, state_d;
    logic [K_W-1:0]   k_q, k_d;
    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;
    vec_t             mat_a_q, mat_a_d;
    vec_t             mat_b_q, mat_b_d;
    logic             err_q, err_d;

    logic             push;
    logic             cap_valid;
    logic [K_W-1:0]   cap_idx;

    rd_tag_pipe #(
        .Depth (READ_LATENCY),
        .IdxW  (K_W)
    ) u_tag_pipe (
        .clk_i       (clk_in),
        .rst_ni      (rst_in),
        .push_i      (push),
        .push_idx_i  (k_q),
        .cap_valid_o (cap_valid),
        .cap_idx_o   (cap_idx)
    );

    // State, issue counter, latched indices and assembled vectors.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            k_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            mat_a_q <= '0;
            mat_b_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            row_q   <= row_d;
            col_q   <= col_d;
            mat_a_q <= mat_a_d;
            mat_b_q <= mat_b_d;
            err_q   <= err_d;
        end
    end

    // Next-state, read issue and capture of returning BRAM data.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        row_d    = row_q;
        col_d    = col_q;
        mat_a_d  = mat_a_q;
        mat_b_d  = mat_b_q;
        err_d    = err_q;
        push     = 1'b0;
        mem_en   = 1'b0;
        a_addr   = '0;
        b_addr   = '0;
        val_rows = 1'b0;

        if ((state_q == FETCH || state_q == DRAIN) && cap_valid) begin
            mat_a_d[cap_idx] = a_data;
            mat_b_d[cap_idx] = b_data;
        end

        unique case (state_q)
            IDLE: begin
                if (new_request) begin
                    row_d = row_req;
                    col_d = col_req;
                    k_d   = '0;
                    if (row_req < IdxLim && col_req < IdxLim) begin
                        state_d = FETCH;
                    end else begin
                        // Out-of-range request: deliver zero vectors without touching memory.
                        state_d = ERR;
                        mat_a_d = '0;
                        mat_b_d = '0;
                        err_d   = 1'b1;
                    end
                end
            end
            FETCH: begin
                mem_en = 1'b1;
                push   = 1'b1;
                a_addr = ADDR_W'(row_q) * ADDR_W'(DIM) + ADDR_W'(k_q);
                b_addr = ADDR_W'(k_q) * ADDR_W'(DIM) + ADDR_W'(col_q);
                k_d    = k_q + 1'b1;
                if (k_q == KLast) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (cap_valid && cap_idx == KLast) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                val_rows = 1'b1;
                state_d  = IDLE;
            end
            ERR: begin
                val_rows = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign matA_row  = mat_a_q;
    assign matB_col  = mat_b_q;
    assign row_in    = row_q;
    assign col_in    = col_q;
    assign busy      = (state_q != IDLE);
    assign range_err = err_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Scoreboard bench for operand_fetch with a two-cycle BRAM model.
module tb_operand_fetch;
    import matmul_pkg::*;

    localparam int AW = 10;

    typedef struct {
        int row;
        int col;
        int cyc;
        bit err;
    } req_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              new_request;
    logic [IDX_W-1:0]  row_req, col_req;
    logic [AW-1:0]     a_addr, b_addr;
    logic [7:0]        a_data, b_data;
    logic              mem_en;
    vec_t              matA_row, matB_col;
    logic [IDX_W-1:0]  row_in, col_in;
    logic              val_rows, busy, range_err;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   issue_k = 0;
    int   val_cnt = 0;
    int   n_exp = 0;
    req_t exp_q[$];

    logic [7:0] a_d1, a_d2, b_d1, b_d2;

    operand_fetch #(
        .READ_LATENCY (2),
        .ADDR_W       (AW)
    ) dut (
        .clk_in      (clk),
        .rst_in      (rst_n),
        .new_request (new_request),
        .row_req     (row_req),
        .col_req     (col_req),
        .a_addr      (a_addr),
        .a_data      (a_data),
        .b_addr      (b_addr),
        .b_data      (b_data),
        .mem_en      (mem_en),
        .matA_row    (matA_row),
        .matB_col    (matB_col),
        .row_in      (row_in),
        .col_in      (col_in),
        .val_rows    (val_rows),
        .busy        (busy),
        .range_err   (range_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM model: A[r][k]=(2r+k)%256, B[k][c]=(3k+c)%256, two-cycle read latency.
    always @(posedge clk) begin
        if (mem_en) begin
            a_d1 <= 8'((2 * (int'(a_addr) / 32) + int'(a_addr) % 32) % 256);
            b_d1 <= 8'((3 * (int'(b_addr) / 32) + int'(b_addr) % 32) % 256);
        end
        a_d2 <= a_d1;
        b_d2 <= b_d1;
    end
    assign a_data = a_d2;
    assign b_data = b_d2;

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic vec_t exp_a(input int r, input bit err);
        vec_t v;
        for (int k = 0; k < 32; k++) v[k] = err ? 8'd0 : 8'((2 * r + k) % 256);
        return v;
    endfunction

    function automatic vec_t exp_b(input int c, input bit err);
        vec_t v;
        for (int k = 0; k < 32; k++) v[k] = err ? 8'd0 : 8'((3 * k + c) % 256);
        return v;
    endfunction

    // Monitor: checks addresses as they issue and vectors when val_rows pulses.
    always @(negedge clk) begin
        req_t e;
        if (!rst_n) begin
            exp_q.delete();
            issue_k = 0;
        end else begin
            if (mem_en) begin
                if (exp_q.size() == 0) begin
                    check_eq("mem_en_unexpected", 1, 0);
                end else begin
                    check_eq("a_addr", a_addr, exp_q[0].row * 32 + issue_k);
                    check_eq("b_addr", b_addr, issue_k * 32 + exp_q[0].col);
                end
                issue_k++;
            end
            if (val_rows) begin
                val_cnt++;
                if (exp_q.size() == 0) begin
                    check_eq("val_rows_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("latency", cyc - e.cyc, e.err ? 1 : 35);
                    check_eq("row_in", row_in, e.row);
                    check_eq("col_in", col_in, e.col);
                    check_eq("matA_row", matA_row, exp_a(e.row, e.err));
                    check_eq("matB_col", matB_col, exp_b(e.col, e.err));
                    check_eq("issue_count", issue_k, e.err ? 0 : 32);
                end
                issue_k = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int r, input int c);
        req_t e;
        e.row = r;
        e.col = c;
        e.cyc = cyc;
        e.err = (r >= 32) || (c >= 32);
        exp_q.push_back(e);
        n_exp++;
    endtask

    task automatic do_req(input int r, input int c);
        row_req     = 6'(r);
        col_req     = 6'(c);
        new_request = 1'b1;
        push_exp(r, c);
        tick();
        new_request = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check_eq("idle_timeout", busy, 0);
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        new_request = 1'b0;
        row_req     = '0;
        col_req     = '0;
        repeat (3) tick();
        check_eq("rst_val_rows", val_rows, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_mem_en", mem_en, 0);
        check_eq("rst_range_err", range_err, 0);
        check_eq("rst_matA", matA_row, 0);
        check_eq("rst_matB", matB_col, 0);
        rst_n = 1'b1;
        tick();

        // Corner (0,0) and far corner (31,31).
        do_req(0, 0);
        wait_idle();
        do_req(31, 31);
        wait_idle();

        // Level request held until val_rows, then a fresh request one cycle later.
        row_req     = 6'd5;
        col_req     = 6'd7;
        new_request = 1'b1;
        push_exp(5, 7);
        n = 0;
        while (!val_rows && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) check_eq("val_timeout", val_rows, 1);
        new_request = 1'b0;
        tick();
        tick();
        do_req(5, 8);
        wait_idle();
        repeat (40) tick();

        // Out-of-range request.
        check_eq("range_err_pre", range_err, 0);
        do_req(40, 3);
        wait_idle();
        check_eq("range_err_set", range_err, 1);
        repeat (3) tick();
        check_eq("range_err_hold", range_err, 1);

        // Inputs scrambled every cycle while fetching (1,1).
        do_req(1, 1);
        n = 0;
        while (busy && n < 200) begin
            row_req = 6'($urandom_range(0, 63));
            col_req = 6'($urandom_range(0, 63));
            tick();
            n++;
        end
        check_eq("range_err_sticky", range_err, 1);

        // Reset in the middle of a fetch.
        do_req(3, 4);
        n_exp--;
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_mem_en", mem_en, 0);
        check_eq("abort_val_rows", val_rows, 0);
        check_eq("abort_matA", matA_row, 0);
        check_eq("abort_matB", matB_col, 0);
        check_eq("abort_range_err", range_err, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        do_req(2, 2);
        wait_idle();
        repeat (5) tick();

        check_eq("val_count", val_cnt, n_exp);
        check_eq("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
